// File: rtl/pixel_cipher_pkg.sv
// rtl/pixel_cipher_pkg.sv - shared state type, mode encodings and channel arithmetic for pixel_cipher_engine
package pixel_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Operands arrive zero-extended; callers keep only the low channel bits, which gives mod 2^DATA_W.
    function automatic logic [31:0] chan_op(input logic [31:0] d, input logic [31:0] k,
                                            input logic [31:0] p, input logic dec);
        return dec ? (d - k - p) : (d + k + p);
    endfunction

endpackage

// File: rtl/pixel_plane_ram.sv
// rtl/pixel_plane_ram.sv - simple dual-port block RAM, one write port and one registered read port
module pixel_plane_ram #(
    parameter int WIDTH  = 24,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_cipher_engine.sv
// rtl/pixel_cipher_engine.sv - multi-channel additive pixel cipher streaming a RAM-held image plane
// Optional chained diffusion is built when PIXEL_CHAIN_EN is defined.
module pixel_cipher_engine #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [NUM_CH*DATA_W-1:0] key_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    import pixel_cipher_pkg::*;

    localparam int W = NUM_CH * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic              busy_q, done_q, mode_q;
    logic [ADDR_W-1:0] rd_addr_q, s1_addr_q;
    logic              rd_v_q;
    logic              out_valid_q, out_last_q;
    logic [W-1:0]      out_data_q;
    logic [ADDR_W-1:0] out_addr_q;

    logic [W-1:0]      rd_data;
    logic [W-1:0]      chain_w;
    logic [W-1:0]      cipher_d;
    logic              fire, issue, start_acc, last_acc;

    assign fire      = rd_v_q & key_valid & (~out_valid_q | out_ready);
    assign issue     = (state_q == RUN) & (~rd_v_q | fire);
    assign start_acc = start & ~busy_q;
    assign last_acc  = out_valid_q & out_ready & out_last_q;

    pixel_plane_ram #(
        .WIDTH  (W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en & ~busy_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data)
    );

`ifdef PIXEL_CHAIN_EN
    // Chain holds the previous ciphertext: the output when encrypting, the input when decrypting.
    logic [W-1:0] chain_q;
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            chain_q <= '0;
        end else if (fire) begin
            chain_q <= (mode_q == MODE_DEC) ? rd_data : cipher_d;
        end
    end
    assign chain_w = chain_q;
`else
    assign chain_w = '0;
`endif

    always_comb begin
        cipher_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cipher_d[c*DATA_W +: DATA_W] = DATA_W'(chan_op(32'(rd_data[c*DATA_W +: DATA_W]),
                                                           32'(key_data[c*DATA_W +: DATA_W]),
                                                           32'(chain_w[c*DATA_W +: DATA_W]),
                                                           mode_q == MODE_DEC));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= MODE_ENC;
            rd_addr_q   <= '0;
            s1_addr_q   <= '0;
            rd_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (issue) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                s1_addr_q <= rd_addr_q;
                rd_v_q    <= 1'b1;
            end else if (fire) begin
                rd_v_q    <= 1'b0;
            end

            if (fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= cipher_d;
                out_addr_q  <= s1_addr_q;
                out_last_q  <= (s1_addr_q == LAST_ADDR);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_acc) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        mode_q    <= mode;
                        rd_addr_q <= '0;
                    end
                end
                RUN: begin
                    if (issue && rd_addr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_acc) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_ready = fire;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_cipher_engine.sv
// tb/tb_pixel_cipher_engine.sv - scoreboard bench for pixel_cipher_engine at DEPTH=16
module tb_pixel_cipher_engine;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst, wr_en, start, mode, key_valid, key_ready, out_valid, out_ready, out_last, busy, done;
    logic [3:0]  wr_addr, out_addr;
    logic [23:0] wr_data, key_data, out_data;

    int checks = 0;
    int failures = 0;
    int beats = 0;
    int kcount = 0;
    int kv_mode = 1;
    int or_mode = 1;
    bit chk_done_nxt = 0;

    logic [28:0] sb[$];
    logic [23:0] img[N];
    logic [23:0] rx[N];
    logic [23:0] exp_data[N];

    pixel_cipher_engine #(.DATA_W(8), .NUM_CH(3), .DEPTH(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .mode(mode), .key_valid(key_valid), .key_ready(key_ready),
        .key_data(key_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] cipher(input logic [23:0] p, input logic [23:0] k,
                                           input logic [23:0] c, input logic dec);
        logic [23:0] r;
        for (int ch = 0; ch < 3; ch++) begin
            r[ch*8 +: 8] = dec ? p[ch*8 +: 8] - k[ch*8 +: 8] - c[ch*8 +: 8]
                               : p[ch*8 +: 8] + k[ch*8 +: 8] + c[ch*8 +: 8];
        end
        return r;
    endfunction

    // Handshake inputs: mode 0 = low, 1 = high, 2 = random
    initial forever begin
        @(posedge clk);
        #2;
        key_valid = (kv_mode == 2) ? 1'($urandom_range(1)) : (kv_mode == 1);
        out_ready = (or_mode == 2) ? 1'($urandom_range(1)) : (or_mode == 1);
    end

    initial forever begin
        logic [28:0] e;
        @(negedge clk);
        if (chk_done_nxt) begin
            chk_done_nxt = 0;
            check("done_after_last", {done, busy}, 2'b10);
        end
        if (key_valid && key_ready) kcount++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=addr%0d required=no_beat", out_addr);
            end else begin
                e = sb.pop_front();
                check("beat", {out_data, out_addr, out_last}, e);
            end
            rx[out_addr] = out_data;
            beats++;
            if (out_last) chk_done_nxt = 1;
        end
    end

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #1;
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = img[i];
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic start_pass(input logic dec, input logic [23:0] key, input bit chk_lat);
        logic [23:0] prev;
        int lat;
        prev = '0;
        for (int i = 0; i < N; i++) begin
            exp_data[i] = cipher(img[i], key, prev, dec);
            sb.push_back({exp_data[i], 4'(i), i == N - 1});
`ifdef PIXEL_CHAIN_EN
            prev = dec ? img[i] : exp_data[i];
`endif
        end
        key_data = key;
        beats = 0;
        kcount = 0;
        @(posedge clk);
        #1;
        mode = dec; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (chk_lat) check("latency", lat, 3);
    endtask

    task automatic finish_pass();
        int t;
        t = 0;
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("pass_done", done, 1'b1);
        check("beat_count", beats, N);
        check("key_count", kcount, N);
        check("sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; mode = 1'b0; key_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_key_ready", key_ready, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 24'h0);
        check("rst_out_addr", out_addr, 4'h0);
        rst = 1'b0;

        // Ramp image, constant key 0x05
        for (int i = 0; i < N; i++) img[i] = 24'(i * 24'h010101);
        load_all();
        start_pass(1'b0, 24'h050505, 1'b1);
        finish_pass();
`ifndef PIXEL_CHAIN_EN
        for (int i = 0; i < N; i++) check("ramp_hand", rx[i], 24'(i * 24'h010101 + 24'h050505));
`endif

        // Random stalls on key and output sides
        kv_mode = 2; or_mode = 2;
        start_pass(1'b0, 24'h050505, 1'b0);
        finish_pass();
        kv_mode = 1; or_mode = 1;

        // Backpressure hold mid-stream
        start_pass(1'b0, 24'h050505, 1'b0);
        t = 0;
        while (!(out_valid && out_addr == 4'd5) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        or_mode = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_data", out_data, exp_data[5]);
            check("bp_addr", out_addr, 4'd5);
            check("bp_key_ready", key_ready, 1'b0);
        end
        or_mode = 1;
        finish_pass();

        // Reset mid-pass, then a full pass from address 0
        start_pass(1'b0, 24'h050505, 1'b0);
        t = 0;
        while (beats < 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        sb.delete();
        start_pass(1'b0, 24'h050505, 1'b1);
        finish_pass();

        // Wrap arithmetic: ch0=FF ch1=80 ch2=00, key ch0=02 ch1=80 ch2=01
        for (int i = 0; i < N; i++) img[i] = 24'h0080FF;
        load_all();
        start_pass(1'b0, 24'h018002, 1'b0);
        finish_pass();
`ifndef PIXEL_CHAIN_EN
        check("wrap_enc", rx[0], 24'h010001);
`endif
        for (int i = 0; i < N; i++) img[i] = rx[i];
        load_all();
        start_pass(1'b1, 24'h018002, 1'b0);
        finish_pass();
        for (int i = 0; i < N; i++) check("wrap_dec", rx[i], 24'h0080FF);

        // Small values on ch0 with key 1; start/wr_en while busy must be ignored
        for (int i = 0; i < N; i++) img[i] = (i < 3) ? 24'(i + 1) : 24'h0;
        load_all();
        start_pass(1'b0, 24'h000001, 1'b0);
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 24'hABCDEF; start = 1'b1; mode = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; start = 1'b0; mode = 1'b0;
        finish_pass();
`ifdef PIXEL_CHAIN_EN
        check("chain_c0", rx[0], 24'd2);
        check("chain_c1", rx[1], 24'd5);
        check("chain_c2", rx[2], 24'd9);
`else
        check("plain_c0", rx[0], 24'd2);
        check("plain_c1", rx[1], 24'd3);
        check("plain_c2", rx[2], 24'd4);
`endif
        for (int i = 0; i < N; i++) img[i] = rx[i];
        load_all();
        start_pass(1'b1, 24'h000001, 1'b0);
        finish_pass();
        check("recover_p0", rx[0], 24'd1);
        check("recover_p1", rx[1], 24'd2);
        check("recover_p2", rx[2], 24'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
